// File: rtl/json_tape_pkg.sv
// Shared types and sizing for the JSON string tape.
package json_tape_pkg;

  localparam int TAPE_BYTES = 32;
  localparam int IDX_W      = $clog2(TAPE_BYTES) + 1;
  localparam int LEN_BYTES  = 4;

  typedef logic [7:0]       UTF8_Char;
  typedef logic [IDX_W-1:0] TapeIndex;

endpackage

// File: rtl/string_tape_accumulator.sv
// Packs lexed string bytes into a tape of {32-bit LE length, payload, 0x00} records.
// Optional sticky `overflow` output when STRING_TAPE_OVERFLOW_FLAG_EN is defined.
module string_tape_accumulator
  import json_tape_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     enable,
  input  UTF8_Char nextStringByte,
  output TapeIndex curIndex,
  output UTF8_Char tape [TAPE_BYTES]
`ifdef STRING_TAPE_OVERFLOW_FLAG_EN
  ,
  output logic     overflow
`endif
);

  localparam int AW = 34;

  UTF8_Char    r_tape [TAPE_BYTES];
  TapeIndex    r_cur;
  logic [31:0] r_count;
  logic        r_in_string;
  logic        r_overflow;

  logic [AW-1:0] w_hdr_addr;
  logic [AW-1:0] w_payload_addr;
  logic [AW-1:0] w_commit_end;
  logic          w_payload_drop;
  logic          w_commit_drop;
  TapeIndex      w_next_cur;

  // Payload address doubles as the terminator address at commit time.
  assign w_hdr_addr     = AW'(r_cur);
  assign w_payload_addr = w_hdr_addr + AW'(LEN_BYTES) + AW'(r_count);
  assign w_commit_end   = w_payload_addr + AW'(1);
  assign w_payload_drop = (w_payload_addr >= AW'(TAPE_BYTES));
  // Terminator sits past every header byte, so it is the first to fall off the end.
  assign w_commit_drop  = w_payload_drop;
  assign w_next_cur     = (w_commit_end >= AW'(TAPE_BYTES)) ? TapeIndex'(TAPE_BYTES)
                                                            : w_commit_end[IDX_W-1:0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < TAPE_BYTES; i++) r_tape[i] <= '0;
      r_cur       <= '0;
      r_count     <= '0;
      r_in_string <= 1'b0;
      r_overflow  <= 1'b0;
    end else if (enable) begin
      for (int i = 0; i < TAPE_BYTES; i++) begin
        if (w_payload_addr == AW'(i)) r_tape[i] <= nextStringByte;
      end
      if (w_payload_drop) r_overflow <= 1'b1;
      r_count     <= r_count + 32'd1;
      r_in_string <= 1'b1;
    end else if (r_in_string) begin
      for (int i = 0; i < TAPE_BYTES; i++) begin
        for (int j = 0; j < LEN_BYTES; j++) begin
          if (w_hdr_addr + AW'(j) == AW'(i)) r_tape[i] <= r_count[8*j +: 8];
        end
        if (w_payload_addr == AW'(i)) r_tape[i] <= 8'h00;
      end
      if (w_commit_drop) r_overflow <= 1'b1;
      r_cur       <= w_next_cur;
      r_count     <= '0;
      r_in_string <= 1'b0;
    end
  end

  assign curIndex = r_cur;
  assign tape     = r_tape;

`ifdef STRING_TAPE_OVERFLOW_FLAG_EN
  assign overflow = r_overflow;
`else
  logic w_unused;
  assign w_unused = r_overflow;
`endif

endmodule

// File: tb/tb_string_tape_accumulator.sv
// Directed bench for string_tape_accumulator with hand-built expected tape images.
module tb_string_tape_accumulator;
  import json_tape_pkg::*;

  logic     clk = 1'b0;
  logic     rst;
  logic     enable;
  UTF8_Char nextStringByte;
  TapeIndex curIndex;
  UTF8_Char tape [TAPE_BYTES];
`ifdef STRING_TAPE_OVERFLOW_FLAG_EN
  logic     overflow;
`endif

  int n_checks = 0;
  int n_fails  = 0;
  logic [7:0] exp_img [TAPE_BYTES];

  string_tape_accumulator dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .nextStringByte (nextStringByte),
    .curIndex       (curIndex),
    .tape           (tape)
`ifdef STRING_TAPE_OVERFLOW_FLAG_EN
    ,
    .overflow       (overflow)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; enable = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic send_string(input string s);
    for (int k = 0; k < s.len(); k++) begin
      enable = 1'b1; nextStringByte = s[k];
      tick();
    end
    enable = 1'b0; nextStringByte = 8'h00;
    tick();
  endtask

  task automatic check_image(input string tag);
    for (int i = 0; i < TAPE_BYTES; i++)
      check_eq($sformatf("%s_tape[%0d]", tag, i), 32'(tape[i]), 32'(exp_img[i]));
  endtask

  task automatic clear_exp();
    for (int i = 0; i < TAPE_BYTES; i++) exp_img[i] = 8'h00;
  endtask

  task automatic exp_two_strings();
    clear_exp();
    exp_img[0] = 8'd5;  exp_img[4] = "a"; exp_img[5] = "p"; exp_img[6] = "p";
    exp_img[7] = "l";   exp_img[8] = "e";
    exp_img[10] = 8'd3; exp_img[14] = "p"; exp_img[15] = "i"; exp_img[16] = "e";
  endtask

  initial begin
    rst = 1'b0; enable = 1'b0; nextStringByte = 8'h00;
    tick(); tick();
    rst = 1'b1;

    // Scribble random partial content, then reset mid-string.
    for (int k = 0; k < 7; k++) begin
      enable = 1'b1; nextStringByte = 8'($urandom_range(1, 255));
      tick();
    end
    do_reset();
    clear_exp();
    check_image("reset");
    check_eq("reset_curIndex", 32'(curIndex), 32'd0);
`ifdef STRING_TAPE_OVERFLOW_FLAG_EN
    check_eq("reset_overflow", 32'(overflow), 32'd0);
`endif

    send_string("apple");
    clear_exp();
    exp_img[0] = 8'd5; exp_img[4] = "a"; exp_img[5] = "p"; exp_img[6] = "p";
    exp_img[7] = "l";  exp_img[8] = "e";
    check_image("apple");
    check_eq("apple_curIndex", 32'(curIndex), 32'd10);

    send_string("pie");
    exp_two_strings();
    check_image("pie");
    check_eq("pie_curIndex", 32'(curIndex), 32'd18);

    do_reset();
    check_eq("rerun_reset_curIndex", 32'(curIndex), 32'd0);
    send_string("apple");
    send_string("pie");
    exp_two_strings();
    check_image("rerun");
    check_eq("rerun_curIndex", 32'(curIndex), 32'd18);

    // Mid-string reset discards the partial string.
    do_reset();
    enable = 1'b1; nextStringByte = "a"; tick();
    nextStringByte = "p"; tick();
    do_reset();
    clear_exp();
    check_image("midrst");
    check_eq("midrst_curIndex", 32'(curIndex), 32'd0);
    send_string("x");
    exp_img[0] = 8'd1; exp_img[4] = "x";
    check_image("x");
    check_eq("x_curIndex", 32'(curIndex), 32'd6);

    // 30-byte string: payload 28..29 and terminator fall off the end.
    do_reset();
    clear_exp();
    for (int k = 0; k < 30; k++) begin
      enable = 1'b1; nextStringByte = 8'(8'h41 + k);
      if (k < 28) exp_img[4 + k] = 8'(8'h41 + k);
      tick();
`ifdef STRING_TAPE_OVERFLOW_FLAG_EN
      if (k == 27) check_eq("ovf_flag_28th", 32'(overflow), 32'd0);
      if (k == 28) check_eq("ovf_flag_29th", 32'(overflow), 32'd1);
`endif
    end
    enable = 1'b0; tick();
    exp_img[0] = 8'h1E;
    check_image("ovf");
    check_eq("ovf_curIndex", 32'(curIndex), 32'd32);
`ifdef STRING_TAPE_OVERFLOW_FLAG_EN
    check_eq("ovf_flag_sticky", 32'(overflow), 32'd1);
`endif

    // Once saturated, further strings leave the tape untouched.
    send_string("zz");
    check_image("sat");
    check_eq("sat_curIndex", 32'(curIndex), 32'd32);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
